pipe_gap_scheduler: RTL and testbench

// Consumer/reader side of the LSFR random source. On a spawn request from the pipe

---
 rtl/pipe_gap_scheduler.sv | 116 +++++++++++
 tb/tb_pipe_gap_scheduler.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_gap_scheduler.sv
// Reader side of the LSFR random source: steps the LSFR on a spawn request, folds the
// sample into the legal gap band by repeated subtraction and hands out gap_top via valid/ack.
module pipe_gap_scheduler #(
  parameter int WIDTH    = 10,
  parameter int MIN_Y    = 40,
  parameter int RANGE    = 300,
  parameter int SHIFTS   = 4,
  parameter int FALLBACK = 150
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] randNum_i,
  output logic             rng_en_o,
  input  logic             spawn_req_i,
  output logic             busy_o,
  output logic [WIDTH-1:0] gap_top_o,
  output logic             gap_valid_o,
  input  logic             gap_ack_i,
  output logic             lockup_o
);

  typedef enum logic [2:0] {
    IDLE,
    DRAW,
    SAMPLE,
    REDUCE,
    DONE
  } state_t;

  localparam logic [WIDTH-1:0] ALL_ONES   = '1;
  localparam logic [WIDTH-1:0] RANGE_W    = WIDTH'(RANGE);
  localparam logic [WIDTH-1:0] MIN_Y_W    = WIDTH'(MIN_Y);
  localparam logic [WIDTH-1:0] FALLBACK_W = WIDTH'(FALLBACK);
  localparam logic [3:0]       LAST_SHIFT = 4'(SHIFTS - 1);

  state_t           state_q;
  logic [3:0]       cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] gap_top_q;
  logic             rng_en_q;
  logic             busy_q;
  logic             gap_valid_q;
  logic             lockup_q;

  // Every output comes straight from a register, so the async reset drops rng_en at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      gap_top_q   <= MIN_Y_W;
      rng_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      gap_valid_q <= 1'b0;
      lockup_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (spawn_req_i) begin
            state_q  <= DRAW;
            cnt_q    <= '0;
            rng_en_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        DRAW: begin
          if (cnt_q == LAST_SHIFT) begin
            state_q  <= SAMPLE;
            rng_en_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        SAMPLE: begin
          // The all-ones value is the XNOR LFSR's stuck state and would repeat forever.
          if (randNum_i == ALL_ONES) begin
            acc_q    <= FALLBACK_W;
            lockup_q <= 1'b1;
          end else begin
            acc_q <= randNum_i;
          end
          state_q <= REDUCE;
        end
        REDUCE: begin
          if (acc_q >= RANGE_W) begin
            acc_q <= acc_q - RANGE_W;
          end else begin
            gap_top_q   <= MIN_Y_W + acc_q;
            gap_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (gap_ack_i) begin
            gap_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          rng_en_q    <= 1'b0;
          busy_q      <= 1'b0;
          gap_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign rng_en_o    = rng_en_q;
  assign busy_o      = busy_q;
  assign gap_top_o   = gap_top_q;
  assign gap_valid_o = gap_valid_q;
  assign lockup_o    = lockup_q;

endmodule

// File: tb/tb_pipe_gap_scheduler.sv
// Self-checking bench for pipe_gap_scheduler: fixed vector table, hand-written corner
// sequences, and randomized requests scored against a modulo-arithmetic reference model.
module tb_pipe_gap_scheduler;

  localparam int WIDTH    = 10;
  localparam int MIN_Y    = 40;
  localparam int RANGE    = 300;
  localparam int SHIFTS   = 4;
  localparam int FALLBACK = 150;
  localparam int ALL_ONES = (1 << WIDTH) - 1;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] randNum;
  logic             rng_en;
  logic             spawn_req;
  logic             busy;
  logic [WIDTH-1:0] gap_top;
  logic             gap_valid;
  logic             gap_ack;
  logic             lockup;

  int passCount  = 0;
  int checkCount = 0;
  int lockModel  = 0;

  typedef struct {
    int r;
    int gap;
    int lat;
    int lock;
  } vec_t;

  vec_t table_q[$];

  pipe_gap_scheduler #(
    .WIDTH(WIDTH), .MIN_Y(MIN_Y), .RANGE(RANGE), .SHIFTS(SHIFTS), .FALLBACK(FALLBACK)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .randNum_i(randNum),
    .rng_en_o(rng_en),
    .spawn_req_i(spawn_req),
    .busy_o(busy),
    .gap_top_o(gap_top),
    .gap_valid_o(gap_valid),
    .gap_ack_i(gap_ack),
    .lockup_o(lockup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // A value that is neither the target nor the lock-up pattern, fed while the LSFR is stepping.
  function automatic int garbage(input int r);
    return (r + 1 + int'($urandom_range(0, 500))) % ALL_ONES;
  endfunction

  // One full request: spawn, step, sample r, wait for valid, hold ackDelay cycles, ack.
  task automatic applyStimulus(input int r, input int expGap, input int expLat,
                               input int expLock, input int ackDelay, input bit noisy,
                               input string tag);
    int edges;
    int enCount;
    bit stable;
    bit idleOk;
    @(negedge clk);
    randNum   = WIDTH'(garbage(r));
    spawn_req = 1'b1;
    @(posedge clk);
    edges   = 1;
    enCount = 0;
    @(negedge clk);
    while (!gap_valid && edges < 40) begin
      if (rng_en) begin
        enCount++;
        randNum = WIDTH'(garbage(r));
      end else begin
        randNum = WIDTH'(r);
      end
      spawn_req = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      gap_ack   = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    gap_ack = 1'b0;
    checkOutput({tag, " latency"}, edges, expLat);
    checkOutput({tag, " rng_en cycles"}, enCount, SHIFTS);
    checkOutput({tag, " gap_top"}, int'(gap_top), expGap);
    checkOutput({tag, " lockup"}, int'(lockup), expLock);
    checkOutput({tag, " busy in DONE"}, int'(busy), 1);
    stable = 1'b1;
    repeat (ackDelay) begin
      spawn_req = noisy;
      @(posedge clk);
      @(negedge clk);
      if (!gap_valid || int'(gap_top) != expGap) stable = 1'b0;
    end
    if (ackDelay > 0) checkOutput({tag, " hold stable"}, int'(stable), 1);
    gap_ack   = 1'b1;
    spawn_req = noisy;
    @(posedge clk);
    @(negedge clk);
    gap_ack   = 1'b0;
    spawn_req = 1'b0;
    checkOutput({tag, " valid after ack"}, int'(gap_valid), 0);
    checkOutput({tag, " busy after ack"}, int'(busy), 0);
    checkOutput({tag, " gap_top kept"}, int'(gap_top), expGap);
    if (noisy) begin
      idleOk = 1'b1;
      repeat (12) begin
        @(posedge clk);
        @(negedge clk);
        if (busy || gap_valid || rng_en) idleOk = 1'b0;
      end
      checkOutput({tag, " stays idle"}, int'(idleOk), 1);
    end
  endtask

  initial begin
    int r, expGap, expLat, ackDelay;
    rst_n     = 1'b0;
    randNum   = '0;
    spawn_req = 1'b0;
    gap_ack   = 1'b0;
    #12;
    checkOutput("reset rng_en", int'(rng_en), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset gap_valid", int'(gap_valid), 0);
    checkOutput("reset gap_top", int'(gap_top), MIN_Y);
    checkOutput("reset lockup", int'(lockup), 0);
    @(negedge clk);
    rst_n = 1'b1;

    table_q.push_back('{r: 0,    gap: 40,  lat: 7,  lock: 0});
    table_q.push_back('{r: 700,  gap: 140, lat: 9,  lock: 0});
    table_q.push_back('{r: 299,  gap: 339, lat: 7,  lock: 0});
    table_q.push_back('{r: 300,  gap: 40,  lat: 8,  lock: 0});
    table_q.push_back('{r: 1022, gap: 162, lat: 10, lock: 0});
    table_q.push_back('{r: 1023, gap: 190, lat: 7,  lock: 1});
    table_q.push_back('{r: 5,    gap: 45,  lat: 7,  lock: 1});
    foreach (table_q[i])
      applyStimulus(table_q[i].r, table_q[i].gap, table_q[i].lat, table_q[i].lock,
                    i % 3, 1'b0, $sformatf("vec%0d", i));

    // Reset lands two cycles into DRAW, well away from any clock edge.
    @(negedge clk);
    randNum   = 10'd5;
    spawn_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    spawn_req = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midDraw rng_en", int'(rng_en), 0);
    checkOutput("midDraw busy", int'(busy), 0);
    checkOutput("midDraw gap_valid", int'(gap_valid), 0);
    checkOutput("midDraw gap_top", int'(gap_top), MIN_Y);
    checkOutput("midDraw lockup", int'(lockup), 0);
    lockModel = 0;
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(650, 90, 9, 0, 2, 1'b1, "ignoredSpawn");
    applyStimulus(700, 140, 9, 0, 20, 1'b0, "longHold");

    for (int n = 0; n < 30; n++) begin
      r = ($urandom_range(0, 7) == 0) ? ALL_ONES : int'($urandom_range(0, ALL_ONES - 1));
      if (r == ALL_ONES) begin
        lockModel = 1;
        expGap    = MIN_Y + FALLBACK;
        expLat    = SHIFTS + 3;
      end else begin
        expGap = MIN_Y + r % RANGE;
        expLat = SHIFTS + 3 + r / RANGE;
      end
      ackDelay = int'($urandom_range(0, 5));
      applyStimulus(r, expGap, expLat, lockModel, ackDelay, n % 5 == 0,
                    $sformatf("rand%0d r=%0d", n, r));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
